// File: rtl/afifo_sync_pkg.sv
// afifo_sync_pkg: shared gray/binary helpers and synchronizer depth bounds
package afifo_sync_pkg;
  localparam int MAXW = 32;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/sync_ptr_chan.sv
// sync_ptr_chan: one gray-pointer synchronizer channel with delta, advance and jump error
module sync_ptr_chan
  import afifo_sync_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int SYNC_STAGES = 2,
  localparam int PW = ADDRSIZE + 1
) (
  input  logic          wclk,
  input  logic          wrst,
  input  logic [PW-1:0] rptr_gray,
  input  logic          err_clr,
  output logic [PW-1:0] wq_rptr_gray,
  output logic [PW-1:0] wq_rptr_bin,
  output logic [PW-1:0] ptr_delta,
  output logic          ptr_adv,
  output logic          ptr_err
);
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDRSIZE);
  logic [SYNC_STAGES-1:0][PW-1:0] chain;
  logic [PW-1:0] g2b, delta;
  assign wq_rptr_gray = chain[SYNC_STAGES-1];
  assign g2b = PW'(gray2bin(MAXW'(wq_rptr_gray)));
  assign delta = g2b - wq_rptr_bin;
  // sync chain, binary conversion, delta/advance and sticky error (set beats clear)
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      chain <= '0;
      wq_rptr_bin <= '0;
      ptr_delta <= '0;
      ptr_adv <= 1'b0;
      ptr_err <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rptr_gray};
      wq_rptr_bin <= g2b;
      ptr_delta <= delta;
      ptr_adv <= delta != '0;
      ptr_err <= (delta > DEPTH) | (ptr_err & ~err_clr);
    end
  end
endmodule

// File: rtl/sync_ptr_multi.sv
// sync_ptr_multi: NCH independent gray-pointer synchronizers sharing the local write clock
module sync_ptr_multi
  import afifo_sync_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int SYNC_STAGES = 2,
  parameter int NCH = 1,
  localparam int PW = ADDRSIZE + 1
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic [NCH*PW-1:0] rptr_gray,
  input  logic [NCH-1:0]    err_clr,
  output logic [NCH*PW-1:0] wq_rptr_gray,
  output logic [NCH*PW-1:0] wq_rptr_bin,
  output logic [NCH*PW-1:0] ptr_delta,
  output logic [NCH-1:0]    ptr_adv,
  output logic [NCH-1:0]    ptr_err
);
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
    $error("sync_ptr_multi: SYNC_STAGES must be 2..4");
  end
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("sync_ptr_multi: NCH must be 1..16");
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sync_ptr_chan #(.ADDRSIZE(ADDRSIZE), .SYNC_STAGES(SYNC_STAGES)) u_chan (
      .wclk(wclk),
      .wrst(wrst),
      .rptr_gray(rptr_gray[c*PW +: PW]),
      .err_clr(err_clr[c]),
      .wq_rptr_gray(wq_rptr_gray[c*PW +: PW]),
      .wq_rptr_bin(wq_rptr_bin[c*PW +: PW]),
      .ptr_delta(ptr_delta[c*PW +: PW]),
      .ptr_adv(ptr_adv[c]),
      .ptr_err(ptr_err[c])
    );
  end
endmodule

// File: tb/tb_sync_ptr_multi.sv
// tb_sync_ptr_multi: directed self-checking bench for sync_ptr_multi
module tb_sync_ptr_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] r2 = '0;
  logic [1:0] clr2 = '0;
  logic [9:0] g2, b2, d2;
  logic [1:0] a2, e2;
  logic [4:0] rs = '0;
  logic [4:0] g3, b3, d3, g4, b4, d4;
  logic a3, e3, a4, e4;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  sync_ptr_multi #(.ADDRSIZE(4), .SYNC_STAGES(2), .NCH(2)) u2 (
    .wclk(clk), .wrst(rst), .rptr_gray(r2), .err_clr(clr2),
    .wq_rptr_gray(g2), .wq_rptr_bin(b2), .ptr_delta(d2), .ptr_adv(a2), .ptr_err(e2)
  );
  sync_ptr_multi #(.ADDRSIZE(4), .SYNC_STAGES(3), .NCH(1)) u3 (
    .wclk(clk), .wrst(rst), .rptr_gray(rs), .err_clr(1'b0),
    .wq_rptr_gray(g3), .wq_rptr_bin(b3), .ptr_delta(d3), .ptr_adv(a3), .ptr_err(e3)
  );
  sync_ptr_multi #(.ADDRSIZE(4), .SYNC_STAGES(4), .NCH(1)) u4 (
    .wclk(clk), .wrst(rst), .rptr_gray(rs), .err_clr(1'b0),
    .wq_rptr_gray(g4), .wq_rptr_bin(b4), .ptr_delta(d4), .ptr_adv(a4), .ptr_err(e4)
  );
  wire [33:0] all2 = {g2, b2, d2, a2, e2};
  wire [16:0] all3 = {g3, b3, d3, a3, e3};
  wire [16:0] all4 = {g4, b4, d4, a4, e4};
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_reset();
    r2 = '0; rs = '0; clr2 = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask
  task automatic test_reset();
    r2 = 10'h3ff; rs = 5'h1f; rst = 1'b1;
    tick(3);
    n_cmp++; if (all2 !== 34'd0) begin n_bad++; $display("FAIL reset_u2 got=%h exp=0", all2); end
    n_cmp++; if ({all3, all4} !== 34'd0) begin n_bad++; $display("FAIL reset_u34 got=%h exp=0", {all3, all4}); end
    r2 = '0; rs = '0;
    tick(1);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      n_cmp++; if ({all2, all3, all4} !== 68'd0) begin n_bad++; $display("FAIL post_reset_%0d got=%h exp=0", k, {all2, all3, all4}); end
    end
  endtask
  task automatic test_single_step();
    r2[4:0] = 5'b00001;
    tick(1);
    n_cmp++; if (g2 !== 10'd0) begin n_bad++; $display("FAIL step_gray_e1 got=%h exp=0", g2); end
    tick(1);
    n_cmp++; if (g2 !== 10'd1 || b2 !== 10'd0) begin n_bad++; $display("FAIL step_gray_e2 got=%h/%h exp=001/000", g2, b2); end
    tick(1);
    n_cmp++; if ({b2, d2, a2, e2} !== {10'd1, 10'd1, 2'b01, 2'b00}) begin n_bad++; $display("FAIL step_e3 bin=%h d=%h adv=%b err=%b exp 001 001 01 00", b2, d2, a2, e2); end
    tick(1);
    n_cmp++; if ({b2, d2, a2} !== {10'd1, 10'd0, 2'b00}) begin n_bad++; $display("FAIL step_e4 bin=%h d=%h adv=%b exp 001 000 00", b2, d2, a2); end
  endtask
  task automatic test_multi_wrap();
    logic [4:0] gv [4] = '{5'b00111, 5'b11111, 5'b10000, 5'b00000};
    logic [4:0] bv [4] = '{5'd5, 5'd21, 5'd31, 5'd0};
    logic [4:0] dv [4] = '{5'd5, 5'd16, 5'd10, 5'd1};
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      r2[4:0] = gv[k];
      tick(3);
      n_cmp++; if ({b2[4:0], d2[4:0], a2[0], e2[0]} !== {bv[k], dv[k], 1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_%0d bin=%0d d=%0d adv=%b err=%b exp %0d %0d 1 0", k, b2[4:0], d2[4:0], a2[0], e2[0], bv[k], dv[k]); end
    end
  endtask
  task automatic test_violation();
    pulse_reset();
    r2[9:5] = 5'b11110;
    tick(3);
    n_cmp++; if ({b2[9:5], d2[9:5], a2, e2} !== {5'd20, 5'd20, 2'b10, 2'b10}) begin n_bad++; $display("FAIL viol_set bin=%0d d=%0d adv=%b err=%b exp 20 20 10 10", b2[9:5], d2[9:5], a2, e2); end
    tick(3);
    n_cmp++; if (e2 !== 2'b10) begin n_bad++; $display("FAIL viol_hold err=%b exp 10", e2); end
    r2[9:5] = 5'b00111;
    tick(2);
    clr2[1] = 1'b1;
    tick(1);
    clr2[1] = 1'b0;
    n_cmp++; if ({d2[9:5], e2} !== {5'd17, 2'b10}) begin n_bad++; $display("FAIL viol_set_wins d=%0d err=%b exp 17 10", d2[9:5], e2); end
    tick(2);
    n_cmp++; if (e2 !== 2'b10) begin n_bad++; $display("FAIL viol_hold2 err=%b exp 10", e2); end
    clr2[1] = 1'b1;
    tick(1);
    clr2[1] = 1'b0;
    n_cmp++; if (e2 !== 2'b00) begin n_bad++; $display("FAIL viol_clear err=%b exp 00", e2); end
    tick(1);
    n_cmp++; if ({b2[4:0], e2} !== {5'd0, 2'b00}) begin n_bad++; $display("FAIL viol_ch0 bin0=%0d err=%b exp 0 00", b2[4:0], e2); end
  endtask
  task automatic test_latency();
    pulse_reset();
    rs = 5'b00001;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_cmp++; if ({b3[0], a3, b4[0], a4} !== {k >= 4, k == 4, k >= 5, k == 5}) begin n_bad++; $display("FAIL lat_e%0d got b3=%0d a3=%b b4=%0d a4=%b exp %b%b%b%b", k, b3, a3, b4, a4, k >= 4, k == 4, k >= 5, k == 5); end
    end
  endtask
  task automatic test_mid_reset();
    pulse_reset();
    r2[4:0] = 5'b00111; rs = 5'b00111;
    tick(6);
    n_cmp++; if ({b2[4:0], b3, b4} !== {5'd5, 5'd5, 5'd5}) begin n_bad++; $display("FAIL mid_pre b2=%0d b3=%0d b4=%0d exp 5 5 5", b2[4:0], b3, b4); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({all2, all3, all4} !== 68'd0) begin n_bad++; $display("FAIL mid_async got=%h exp=0", {all2, all3, all4}); end
    tick(1);
    rst = 1'b0;
    tick(3);
    n_cmp++; if ({b2[4:0], d2[4:0], a2[0], e2[0]} !== {5'd5, 5'd5, 1'b1, 1'b0}) begin n_bad++; $display("FAIL mid_rel bin=%0d d=%0d adv=%b err=%b exp 5 5 1 0", b2[4:0], d2[4:0], a2[0], e2[0]); end
    tick(2);
    n_cmp++; if ({d4, a4} !== {5'd5, 1'b1}) begin n_bad++; $display("FAIL mid_rel4 d=%0d adv=%b exp 5 1", d4, a4); end
  endtask
  initial begin
    test_reset();
    test_single_step();
    test_multi_wrap();
    test_violation();
    test_latency();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_ptr_multi.md
# sync_ptr_multi

Multi-channel, parametrised gray-pointer synchronizer for the aFifo family. Each channel moves a gray-coded FIFO pointer from a foreign clock domain into the local `wclk` domain through a configurable-depth flop chain. It then converts the pointer to binary, reports per-cycle advance and step size, and flags implausible pointer jumps with a sticky error. It replaces the fixed two-stage pointer synchronizer in multi-FIFO spy-buffer arrangements where several read pointers share one write clock.

## Interface
Parameters:
- `ADDRSIZE`, 4: FIFO address bits; pointer width is `PW = ADDRSIZE+1`; depth `2**ADDRSIZE`.
- `SYNC_STAGES`, 2: synchronizer flop count per bit; legal range 2..4 (elaboration error otherwise).
- `NCH`, 1: number of independent pointer channels; legal range 1..16.

Ports:
- `wclk`  in  1  local clock; every register in the block is on its rising edge.
- `wrst`  in  1  reset, asynchronous, active-high; clears all state.
- `rptr_gray`  in  NCH*PW  foreign-domain gray pointers; channel c occupies bits [c*PW +: PW].
- `err_clr`  in  NCH  per-channel clear for `ptr_err`.
- `wq_rptr_gray`  out  NCH*PW  synchronized gray pointers (last chain stage).
- `wq_rptr_bin`  out  NCH*PW  registered binary equivalent.
- `ptr_delta`  out  NCH*PW  binary advance since previous sample, modulo 2**PW.
- `ptr_adv`  out  NCH  high for one cycle when `ptr_delta` is non-zero.
- `ptr_err`  out  NCH  sticky jump-violation flag.

## Operation
- Per channel, per bit: a chain of `SYNC_STAGES` flops. The chain has no logic between stages; `wq_rptr_gray` is the last stage.
- Conversion stage: `g2b = gray2bin(wq_rptr_gray)`, using the standard XOR-prefix from the MSB.
- On each edge:
  - `wq_rptr_bin <= g2b`.
  - `ptr_delta <= g2b - wq_rptr_bin`, PW-bit unsigned subtraction with wrap, so a rollover from 31 to 0 gives 1.
  - `ptr_adv <= (g2b != wq_rptr_bin)`.
- Violation: if the computed delta is greater than `2**ADDRSIZE`, the pointer has moved more than a full FIFO in one sample. In that case `ptr_err[c] <= 1`.
- Clearing: `err_clr[c]` clears `ptr_err[c]` on the next edge. If a set and a clear occur on the same edge, set wins.
- Channels are fully independent. They share no state.
- No handshake: the source guarantees gray discipline, with one bit changing per source-clock step.

## Timing
- Reset value is 0 for every output and every internal flop. After `wrst` deasserts with the input at 0, there is no spurious `ptr_adv`.
- Latency from input change to `wq_rptr_gray`: `SYNC_STAGES` edges.
- Latency from input change to `wq_rptr_bin`, `ptr_delta`, `ptr_adv`, `ptr_err`: `SYNC_STAGES+1` edges. All four update on the same edge.
- `ptr_adv` is a single-cycle pulse per changed sample. For consecutive changes it stays high with updated `ptr_delta`.
- Reset mid-operation: all state returns to 0 asynchronously. After release, the first non-zero synchronized sample reports its delta relative to 0.
- Wrap-around is legal, with no error. A delta of exactly `2**ADDRSIZE` is legal, as a full FIFO.

## Structure
- Shared package `afifo_sync_pkg`:
  - `gray2bin` and `bin2gray` functions, parametrised by width through a width-generic loop.
  - Localparam defaults for `SYNC_STAGES` bounds.
- Sub-module `sync_ptr_chan`: one channel, containing the chain, conversion, delta and error logic. The top level is a generate loop over `NCH`, plus port slicing.

## Test plan
- Reset, with ADDRSIZE=4, SYNC_STAGES=2, NCH=2: assert `wrst` with non-zero inputs → all outputs 0 during reset and for 3 edges after release with inputs held at 0.
- Single step: ch0 gray 00000→00001 → `wq_rptr_gray`=00001 after 2 edges; at edge 3, `wq_rptr_bin`=1, `ptr_delta`=1, `ptr_adv`=1 for exactly one cycle.
- Multi-step and wrap:
  - ch0 bin 0→5 (gray 00111) → `ptr_delta`=5, no error.
  - Then bin 31→0 (gray 10000→00000) → `ptr_delta`=1, `ptr_err`=0.
- Violation: ch1 bin 0→20 (gray 11110) → `ptr_delta`=20, `ptr_err[1]`=1 and held. Pulse `err_clr[1]` on the same edge as a second violation → stays 1. Clear alone → 0 next edge. ch0 is unaffected.
- Latency sweep: SYNC_STAGES=3 and 4 → binary outputs appear exactly 4 and 5 edges after the input change. Mid-stream `wrst` pulse → immediate zeros, then delta is measured relative to 0.
